// File: rtl/pipelined_dual_port_mem_pkg.sv
// Shared types and constants for the dual-port instruction/data memory.
package mem_pkg;

    // Sequencer states: zeroing the array after reset, then normal service.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mem_state_t;

    // Supported read latencies, in cycles from the accept edge.
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    // Number of words addressed by an addr_w-bit address.
    function automatic int mem_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/pipelined_dual_port_mem_if.sv
// Port bundle for the dual-port memory: port A fetch, port B load/store, init status.
interface pipelined_dual_port_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              a_en;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_rdata;
    logic              a_rvalid;

    logic              b_en;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ready;
    logic [DATA_W-1:0] b_rdata;
    logic              b_rvalid;

    logic              init_busy;

    // Pipeline side: issues fetches and loads/stores.
    modport master (
        output a_en, a_addr, b_en, b_we, b_addr, b_wdata,
        input  a_rdata, a_rvalid, b_ready, b_rdata, b_rvalid, init_busy
    );

    // Memory side.
    modport slave (
        input  a_en, a_addr, b_en, b_we, b_addr, b_wdata,
        output a_rdata, a_rvalid, b_ready, b_rdata, b_rvalid, init_busy
    );
endinterface

// File: rtl/pipelined_dual_port_mem_read_pipe.sv
// Read-data delay line: carries a valid flag and its data READ_LAT stages.
// Data registers only load with a valid beat, so the output holds its last value.
module mem_read_pipe
    import mem_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_lat_check
        $error("mem_read_pipe: READ_LAT must be 1 or 2");
    end

    logic [READ_LAT-1:0] vld;
    logic [DATA_W-1:0]   dat [READ_LAT];

    // Shift valid every cycle; advance data only alongside a valid beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[READ_LAT-1];
    assign out_data  = dat[READ_LAT-1];

endmodule

// File: rtl/pipelined_dual_port_mem.sv
// Shared instruction/data memory: port A fetch (read-only), port B load/store,
// write-first forwarding from B to A, optional zero-fill after reset.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   CLEAR | zeroing mem[clr_cnt] each cycle; both ports ignored
//   RUN   | normal service; terminal until the next reset
module pipelined_dual_port_mem
    import mem_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    pipelined_dual_port_mem_if.slave   bus
);

    localparam int              DEPTH       = mem_depth(ADDR_W);
    localparam logic [ADDR_W:0] CLR_LAST    = (ADDR_W + 1)'(DEPTH - 1);
    localparam mem_state_t      RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    logic [DATA_W-1:0] mem [DEPTH];

    mem_state_t        state;
    logic [ADDR_W:0]   clr_cnt;
    logic              init_busy_q;

    logic              b_acc;
    logic              b_wr;
    logic              b_rd;
    logic              a_acc;
    logic [DATA_W-1:0] a_sample;
    logic [DATA_W-1:0] b_sample;

    assign bus.b_ready   = (state == RUN);
    assign bus.init_busy = init_busy_q;

    assign b_acc = bus.b_en & bus.b_ready;
    assign b_wr  = b_acc & bus.b_we;
    assign b_rd  = b_acc & ~bus.b_we;
    assign a_acc = bus.a_en & (state == RUN);

    // A port B write to the fetched address wins on the same edge.
    assign a_sample = (b_wr && (bus.b_addr == bus.a_addr)) ? bus.b_wdata : mem[bus.a_addr];
    assign b_sample = mem[bus.b_addr];

    // Clear sequencer: walk the whole array once, then stay in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RESET_STATE;
            clr_cnt     <= '0;
            init_busy_q <= (CLEAR_ON_RESET != 0);
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) begin
                state       <= RUN;
                init_busy_q <= 1'b0;
            end
        end
    end

    // Array writes: zero-fill while clearing, otherwise accepted port B stores.
    always_ff @(posedge clk) begin
        if (state == CLEAR && !rst) begin
            mem[clr_cnt[ADDR_W-1:0]] <= '0;
        end else if (b_wr) begin
            mem[bus.b_addr] <= bus.b_wdata;
        end
    end

    mem_read_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_pipe_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_acc),
        .in_data   (a_sample),
        .out_valid (bus.a_rvalid),
        .out_data  (bus.a_rdata)
    );

    mem_read_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_pipe_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_rd),
        .in_data   (b_sample),
        .out_valid (bus.b_rvalid),
        .out_data  (bus.b_rdata)
    );

endmodule
